// File: rtl/shiftreg_n.sv
// shiftreg_n: DEPTH-stage enable/clear delay line with per-stage valid,
// runtime read tap, tail port and saturating fill count.
module shiftreg_n #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 8,
  parameter int TAP_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_valid,
  input  logic [TAP_WIDTH-1:0]  tap_sel,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] tail_data,
  output logic                  tail_valid,
  output logic [TAP_WIDTH:0]    fill_count,
  output logic                  primed,
  output logic                  tap_err
);

  localparam logic [TAP_WIDTH:0] FULL =
    (TAP_WIDTH+1)'(DEPTH);
  localparam logic [TAP_WIDTH:0] ONE =
    (TAP_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [TAP_WIDTH:0]    fill_q;

  always_ff @(posedge clock) begin
    if (reset || (enable && clear)) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else if (enable) begin
      stage_q[0] <= write_data;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      vld_q <= {vld_q[DEPTH-2:0], write_valid};
      if (fill_q != FULL) begin
        fill_q <= fill_q + ONE;
      end
    end
  end

  // Decoded mux: an out-of-range tap matches no stage and reads zero.
  always_comb begin
    read_data  = '0;
    read_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_WIDTH'(i)) begin
        read_data  = stage_q[i];
        read_valid = vld_q[i];
      end
    end
  end

  assign tap_err    = {1'b0, tap_sel} >= FULL;
  assign tail_data  = stage_q[DEPTH-1];
  assign tail_valid = vld_q[DEPTH-1];
  assign fill_count = fill_q;
  assign primed     = (fill_q == FULL);

endmodule
